// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates one entry per renamed op at dispatch, absorbs
// completion strobes from the arith, mem and term pipelines, and retires ops
// strictly in program order. Each retirement publishes the arch->phys mapping
// and frees the superseded physical tags. A retiring failed term op raises a
// one-cycle flush and discards all younger entries.
//
// Optional feature: define ROB_PERF_EN to add the perf_commits / perf_flushes
// counter outputs. The default build has neither the ports nor the counters.

`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module reorder_buffer #(
    parameter int unsigned ROB_AW = 5,
    parameter int unsigned PR_W   = `PR_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,

    // Dispatch / allocation
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [7:0]          alloc_arch,
    input  logic [2*PR_W-1:0]   alloc_phys,
    input  logic [2*PR_W-1:0]   alloc_old_phys,
    input  logic [1:0]          alloc_dmask,
    output logic [ROB_AW-1:0]   alloc_entry,

    // Completion strobes
    input  logic                cmp_arith_valid,
    input  logic [ROB_AW-1:0]   cmp_arith_entry,
    input  logic                cmp_mem_valid,
    input  logic [ROB_AW-1:0]   cmp_mem_entry,
    input  logic                cmp_term_valid,
    input  logic [ROB_AW-1:0]   cmp_term_entry,
    input  logic                cmp_term_failed,

    // Commit
    output logic                commit_valid,
    output logic [7:0]          commit_arch,
    output logic [2*PR_W-1:0]   commit_phys,
    output logic [1:0]          commit_dmask,
    output logic [2*PR_W-1:0]   free_phys,
    output logic [1:0]          free_valid,
    output logic                flush,
    output logic                empty
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]         perf_commits,
    output logic [15:0]         perf_flushes
`endif
);

    localparam int unsigned DEPTH = 2 ** ROB_AW;

    // Pointers and count carry one extra bit: the pointer MSB is the wrap bit,
    // and count reaches exactly DEPTH only when full.
    localparam logic [ROB_AW:0] PTR_ONE = {{ROB_AW{1'b0}}, 1'b1};

    logic [ROB_AW:0]    head_q, head_d;
    logic [ROB_AW:0]    tail_q, tail_d;
    logic [ROB_AW:0]    count_q, count_d;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   done_q, done_d;
    logic [DEPTH-1:0]   failed_q, failed_d;

    logic [7:0]         arch_q     [DEPTH];
    logic [2*PR_W-1:0]  phys_q     [DEPTH];
    logic [2*PR_W-1:0]  old_phys_q [DEPTH];
    logic [1:0]         dmask_q    [DEPTH];

    logic               commit_valid_q;
    logic [7:0]         commit_arch_q;
    logic [2*PR_W-1:0]  commit_phys_q;
    logic [1:0]         commit_dmask_q;
    logic [2*PR_W-1:0]  free_phys_q;
    logic [1:0]         free_valid_q;
    logic               flush_q;

    logic [ROB_AW-1:0]  head_idx;
    logic [ROB_AW-1:0]  tail_idx;
    logic               alloc_fire;
    logic               commit_go;
    logic               commit_flush;

    assign head_idx = head_q[ROB_AW-1:0];
    assign tail_idx = tail_q[ROB_AW-1:0];

    // Ready depends only on registered state: no bypass from a same-cycle
    // retirement, and nothing is accepted while the flush pulse is high.
    assign alloc_ready  = ~count_q[ROB_AW] & ~flush_q;
    assign alloc_fire   = alloc_valid & alloc_ready;
    assign alloc_entry  = tail_idx;
    assign empty        = (count_q == '0);

    assign commit_go    = valid_q[head_idx] & done_q[head_idx];
    assign commit_flush = commit_go & failed_q[head_idx];

    assign commit_valid = commit_valid_q;
    assign commit_arch  = commit_arch_q;
    assign commit_phys  = commit_phys_q;
    assign commit_dmask = commit_dmask_q;
    assign free_phys    = free_phys_q;
    assign free_valid   = free_valid_q;
    assign flush        = flush_q;

    // Next-state for entry status bits, pointers and occupancy count
    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        failed_d = failed_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        // Completions only land on live entries; several ports on one index OR
        if (!flush_q) begin
            if (cmp_arith_valid && valid_q[cmp_arith_entry]) begin
                done_d[cmp_arith_entry] = 1'b1;
            end
            if (cmp_mem_valid && valid_q[cmp_mem_entry]) begin
                done_d[cmp_mem_entry] = 1'b1;
            end
            if (cmp_term_valid && valid_q[cmp_term_entry]) begin
                done_d[cmp_term_entry]   = 1'b1;
                failed_d[cmp_term_entry] = cmp_term_failed;
            end
        end

        if (commit_go) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end

        // Allocation overrides any stale status left at the tail slot
        if (alloc_fire) begin
            valid_d[tail_idx]  = 1'b1;
            done_d[tail_idx]   = 1'b0;
            failed_d[tail_idx] = 1'b0;
            tail_d             = tail_q + PTR_ONE;
        end

        case ({alloc_fire, commit_go})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // A retiring failed term op wipes everything younger, including any
        // allocation landing on the same edge.
        if (commit_flush) begin
            valid_d  = '0;
            done_d   = '0;
            failed_d = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    // Control state: pointers, count and per-entry status bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            done_q   <= '0;
            failed_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            failed_q <= failed_d;
        end
    end

    // Entry payload storage; contents are only meaningful while valid is set
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            arch_q[tail_idx]     <= alloc_arch;
            phys_q[tail_idx]     <= alloc_phys;
            old_phys_q[tail_idx] <= alloc_old_phys;
            dmask_q[tail_idx]    <= alloc_dmask;
        end
    end

    // Registered commit outputs; payload holds its last value between commits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_valid_q <= 1'b0;
            commit_arch_q  <= '0;
            commit_phys_q  <= '0;
            commit_dmask_q <= '0;
            free_phys_q    <= '0;
            free_valid_q   <= '0;
            flush_q        <= 1'b0;
        end else begin
            commit_valid_q <= commit_go;
            commit_dmask_q <= commit_go ? dmask_q[head_idx] : 2'b00;
            free_valid_q   <= commit_go ? dmask_q[head_idx] : 2'b00;
            flush_q        <= commit_flush;
            if (commit_go) begin
                commit_arch_q <= arch_q[head_idx];
                commit_phys_q <= phys_q[head_idx];
                free_phys_q   <= old_phys_q[head_idx];
            end
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] perf_commits_q;
    logic [15:0] perf_flushes_q;

    assign perf_commits = perf_commits_q;
    assign perf_flushes = perf_flushes_q;

    // Free-running event counters, advancing on the edge that raises the
    // corresponding output; both wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_commits_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (commit_go) begin
                perf_commits_q <= perf_commits_q + 32'd1;
            end
            if (commit_flush) begin
                perf_flushes_q <= perf_flushes_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: out-of-order completion with in-order
// retirement, full-buffer backpressure across the index wrap, multi-port
// completion in one cycle, failed-term flush, asynchronous reset and (when
// ROB_PERF_EN is defined) the perf counters.

module tb_reorder_buffer;

    localparam int AW = 5;
    localparam int PW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [7:0]      alloc_arch;
    logic [2*PW-1:0] alloc_phys;
    logic [2*PW-1:0] alloc_old_phys;
    logic [1:0]      alloc_dmask;
    logic [AW-1:0]   alloc_entry;
    logic            cmp_arith_valid;
    logic [AW-1:0]   cmp_arith_entry;
    logic            cmp_mem_valid;
    logic [AW-1:0]   cmp_mem_entry;
    logic            cmp_term_valid;
    logic [AW-1:0]   cmp_term_entry;
    logic            cmp_term_failed;
    logic            commit_valid;
    logic [7:0]      commit_arch;
    logic [2*PW-1:0] commit_phys;
    logic [1:0]      commit_dmask;
    logic [2*PW-1:0] free_phys;
    logic [1:0]      free_valid;
    logic            flush;
    logic            empty;
`ifdef ROB_PERF_EN
    logic [31:0]     perf_commits;
    logic [15:0]     perf_flushes;
`endif

    int checks = 0;
    int errors = 0;

    logic [32:0] got_commit;
    assign got_commit = {commit_valid, commit_arch, commit_phys, commit_dmask,
                         free_phys, free_valid};

    reorder_buffer #(
        .ROB_AW (AW),
        .PR_W   (PW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_arch      (alloc_arch),
        .alloc_phys      (alloc_phys),
        .alloc_old_phys  (alloc_old_phys),
        .alloc_dmask     (alloc_dmask),
        .alloc_entry     (alloc_entry),
        .cmp_arith_valid (cmp_arith_valid),
        .cmp_arith_entry (cmp_arith_entry),
        .cmp_mem_valid   (cmp_mem_valid),
        .cmp_mem_entry   (cmp_mem_entry),
        .cmp_term_valid  (cmp_term_valid),
        .cmp_term_entry  (cmp_term_entry),
        .cmp_term_failed (cmp_term_failed),
        .commit_valid    (commit_valid),
        .commit_arch     (commit_arch),
        .commit_phys     (commit_phys),
        .commit_dmask    (commit_dmask),
        .free_phys       (free_phys),
        .free_valid      (free_valid),
        .flush           (flush),
        .empty           (empty)
`ifdef ROB_PERF_EN
        ,
        .perf_commits    (perf_commits),
        .perf_flushes    (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    // Per-op payload, derived from a bench-side op number
    function automatic logic [7:0] f_arch(input int op);
        return 8'(op * 13 + 7);
    endfunction
    function automatic logic [2*PW-1:0] f_phys(input int op);
        return (2*PW)'(op * 37 + 3);
    endfunction
    function automatic logic [2*PW-1:0] f_old(input int op);
        return (2*PW)'(op * 29 + 11);
    endfunction
    function automatic logic [1:0] f_dmask(input int op);
        return 2'(op % 3 + 1);
    endfunction
    function automatic logic [32:0] exp_commit(input int op);
        return {1'b1, f_arch(op), f_phys(op), f_dmask(op), f_old(op), f_dmask(op)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid     = 1'b0;
        alloc_arch      = '0;
        alloc_phys      = '0;
        alloc_old_phys  = '0;
        alloc_dmask     = '0;
        cmp_arith_valid = 1'b0;
        cmp_arith_entry = '0;
        cmp_mem_valid   = 1'b0;
        cmp_mem_entry   = '0;
        cmp_term_valid  = 1'b0;
        cmp_term_entry  = '0;
        cmp_term_failed = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic set_alloc(input int op);
        alloc_valid    = 1'b1;
        alloc_arch     = f_arch(op);
        alloc_phys     = f_phys(op);
        alloc_old_phys = f_old(op);
        alloc_dmask    = f_dmask(op);
    endtask

    task automatic do_alloc(input int op);
        set_alloc(op);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic clear_cmp();
        cmp_arith_valid = 1'b0;
        cmp_mem_valid   = 1'b0;
        cmp_term_valid  = 1'b0;
        cmp_term_failed = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        checks++;
        if (got_commit !== 33'd0) begin
            errors++;
            $display("FAIL reset_commit: got %h exp %h", got_commit, 33'd0);
        end
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: got %b exp 0", flush);
        end
        checks++;
        if (alloc_ready !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_empty: got %b%b exp 11", alloc_ready, empty);
        end
        checks++;
        if (alloc_entry !== 5'd0) begin
            errors++;
            $display("FAIL reset_entry: got %0d exp 0", alloc_entry);
        end
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_out_of_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alloc_entry !== 5'(i)) begin
                errors++;
                $display("FAIL ooo_alloc_entry: got %0d exp %0d", alloc_entry, i);
            end
            do_alloc(i + 1);
        end
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL ooo_not_empty: got %b exp 0", empty);
        end
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd2;
        tick();
        clear_cmp();
        cmp_mem_valid = 1'b1;
        cmp_mem_entry = 5'd0;
        tick();
        clear_cmp();
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL ooo_early_commit: got %b exp 0", commit_valid);
        end
        cmp_term_valid  = 1'b1;
        cmp_term_entry  = 5'd1;
        cmp_term_failed = 1'b0;
        tick();
        clear_cmp();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_commit !== exp_commit(k + 1) || flush !== 1'b0) begin
                errors++;
                $display("FAIL ooo_commit%0d: got %h/%b exp %h/0", k, got_commit, flush,
                         exp_commit(k + 1));
            end
            tick();
        end
        checks++;
        if (commit_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ooo_drained: got valid %b empty %b exp 0 1", commit_valid, empty);
        end
    endtask

    // Continues from the previous test: head = tail = 3, so the fill wraps 31->0
    task automatic test_full();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (alloc_entry !== 5'((3 + i) % 32) || alloc_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d: got entry %0d ready %b exp %0d 1", i,
                         alloc_entry, alloc_ready, (3 + i) % 32);
            end
            do_alloc(100 + i);
        end
        checks++;
        if (alloc_ready !== 1'b0 || alloc_entry !== 5'd3) begin
            errors++;
            $display("FAIL full_ready: got ready %b entry %0d exp 0 3", alloc_ready, alloc_entry);
        end
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd3;
        tick();
        clear_cmp();
        checks++;
        if (commit_valid !== 1'b0 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pre_commit: got valid %b ready %b exp 0 0", commit_valid,
                     alloc_ready);
        end
        // Retirement happens on this edge; the offered alloc must be refused
        set_alloc(200);
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (got_commit !== exp_commit(100)) begin
            errors++;
            $display("FAIL full_commit: got %h exp %h", got_commit, exp_commit(100));
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_entry !== 5'd3) begin
            errors++;
            $display("FAIL full_refused: got ready %b entry %0d exp 1 3", alloc_ready, alloc_entry);
        end
        do_alloc(200);
        checks++;
        if (alloc_ready !== 1'b0 || alloc_entry !== 5'd4) begin
            errors++;
            $display("FAIL full_refill: got ready %b entry %0d exp 0 4", alloc_ready, alloc_entry);
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        for (int i = 0; i < 6; i++) do_alloc(300 + i);
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd3;
        tick();
        clear_cmp();
        cmp_mem_valid = 1'b1;
        cmp_mem_entry = 5'd2;
        tick();
        clear_cmp();
        cmp_term_valid = 1'b1;
        cmp_term_entry = 5'd1;
        tick();
        clear_cmp();
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd4;
        cmp_mem_valid   = 1'b1;
        cmp_mem_entry   = 5'd4;
        cmp_term_valid  = 1'b1;
        cmp_term_entry  = 5'd5;
        tick();
        clear_cmp();
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd0;
        tick();
        clear_cmp();
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_no_commit_yet: got %b exp 0", commit_valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (got_commit !== exp_commit(300 + k) || flush !== 1'b0) begin
                errors++;
                $display("FAIL same_commit%0d: got %h/%b exp %h/0", k, got_commit, flush,
                         exp_commit(300 + k));
            end
        end
        tick();
        checks++;
        if (commit_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL same_no_dup: got valid %b empty %b exp 0 1", commit_valid, empty);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        do_alloc(400);
        do_alloc(401);
        do_alloc(402);
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd0;
        cmp_term_valid  = 1'b1;
        cmp_term_entry  = 5'd1;
        cmp_term_failed = 1'b1;
        cmp_mem_valid   = 1'b1;
        cmp_mem_entry   = 5'd2;
        tick();
        clear_cmp();
        tick();
        checks++;
        if (got_commit !== exp_commit(400) || flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_commit0: got %h/%b exp %h/0", got_commit, flush,
                     exp_commit(400));
        end
        tick();
        checks++;
        if (got_commit !== exp_commit(401) || flush !== 1'b1) begin
            errors++;
            $display("FAIL flush_commit1: got %h/%b exp %h/1", got_commit, flush,
                     exp_commit(401));
        end
        checks++;
        if (alloc_ready !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle_state: got ready %b empty %b exp 0 1", alloc_ready, empty);
        end
        // Both of these land in the flush cycle and must be dropped
        set_alloc(405);
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd0;
        tick();
        alloc_valid = 1'b0;
        clear_cmp();
        checks++;
        if (commit_valid !== 1'b0 || flush !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got valid %b flush %b empty %b exp 0 0 1", commit_valid,
                     flush, empty);
        end
        checks++;
        if (alloc_entry !== 5'd0 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_entry: got entry %0d ready %b exp 0 1", alloc_entry, alloc_ready);
        end
        do_alloc(410);
        tick();
        tick();
        checks++;
        if (commit_valid !== 1'b0 || alloc_entry !== 5'd1) begin
            errors++;
            $display("FAIL flush_stale: got valid %b entry %0d exp 0 1", commit_valid, alloc_entry);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) do_alloc(500 + i);
        cmp_arith_valid = 1'b1;
        cmp_arith_entry = 5'd0;
        cmp_mem_valid   = 1'b1;
        cmp_mem_entry   = 5'd1;
        tick();
        clear_cmp();
        tick();
        checks++;
        if (got_commit !== exp_commit(500)) begin
            errors++;
            $display("FAIL areset_pre: got %h exp %h", got_commit, exp_commit(500));
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (got_commit !== 33'd0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL areset_outputs: got %h/%b exp 0/0", got_commit, flush);
        end
        checks++;
        if (empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_entry !== 5'd0) begin
            errors++;
            $display("FAIL areset_state: got empty %b ready %b entry %0d exp 1 1 0", empty,
                     alloc_ready, alloc_entry);
        end
        #2;
        rst = 1'b1;
        tick();
        checks++;
        if (commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_commit: got %b exp 0", commit_valid);
        end
        do_alloc(520);
        checks++;
        if (alloc_entry !== 5'd1) begin
            errors++;
            $display("FAIL areset_realloc: got %0d exp 1", alloc_entry);
        end
    endtask

`ifdef ROB_PERF_EN
    task automatic test_perf();
        logic [AW-1:0] e;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            do_alloc(600 + 2 * r);
            do_alloc(601 + 2 * r);
            cmp_arith_valid = 1'b1;
            cmp_arith_entry = 5'd0;
            cmp_term_valid  = 1'b1;
            cmp_term_entry  = 5'd1;
            cmp_term_failed = 1'b1;
            tick();
            clear_cmp();
            repeat (3) tick();
        end
        for (int j = 0; j < 94; j++) begin
            e = alloc_entry;
            do_alloc(700 + j);
            cmp_arith_valid = 1'b1;
            cmp_arith_entry = e;
            tick();
            clear_cmp();
        end
        tick();
        tick();
        checks++;
        if (perf_commits !== 32'd100) begin
            errors++;
            $display("FAIL perf_commits: got %0d exp 100", perf_commits);
        end
        checks++;
        if (perf_flushes !== 16'd3) begin
            errors++;
            $display("FAIL perf_flushes: got %0d exp 3", perf_flushes);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_out_of_order();
        test_full();
        test_same_cycle();
        test_flush();
        test_async_reset();
`ifdef ROB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement end of the execution completion interface.
- Allocates one entry per renamed op at dispatch.
- Absorbs the per-pipeline completion strobes (arith, mem, term) tagged by ROB entry index.
- Commits completed ops strictly in program order: publishes architectural→physical register updates, releases the superseded physical registers, and raises a flush when a failed terminate op retires.

Parameters:
- ROB_AW, 5: entry index width; DEPTH = 2**ROB_AW = 32 entries.
- PR_W, `PR_ADDR_W (5): physical register tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  dispatch presents a renamed op.
- alloc_ready  out  1  entry available (count < DEPTH and not flushing).
- alloc_arch  in  8  two 4-bit architectural dest regs {value, flags}.
- alloc_phys  in  2*PR_W  newly mapped physical tags.
- alloc_old_phys  in  2*PR_W  previously mapped tags, freed at commit.
- alloc_dmask  in  2  which of the two dests are real writes.
- alloc_entry  out  ROB_AW  index granted, equals tail pointer.
- cmp_arith_valid  in  1  arith pipeline completion.
- cmp_arith_entry  in  ROB_AW  arith completion index.
- cmp_mem_valid  in  1  mem pipeline completion.
- cmp_mem_entry  in  ROB_AW  mem completion index.
- cmp_term_valid  in  1  term pipeline completion.
- cmp_term_entry  in  ROB_AW  term completion index.
- cmp_term_failed  in  1  term op resolved as failed.
- commit_valid  out  1  one op retired this cycle.
- commit_arch  out  8  retired architectural dests.
- commit_phys  out  2*PR_W  retired physical tags.
- commit_dmask  out  2  valid dests of retired op.
- free_phys  out  2*PR_W  tags returned to free list.
- free_valid  out  2  per-slot free strobe (= commit_dmask when commit_valid).
- flush  out  1  one-cycle pulse: failed term committed, younger state discarded.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, async): head = tail = 0, count = 0, all entry valid/done/failed bits cleared.
- Reset output values: commit_valid, free_valid, commit_dmask, flush = 0; commit_arch, commit_phys, free_phys = 0; alloc_ready = 1; empty = 1.
- Pointers carry an extra wrap bit; index = low ROB_AW bits; wrap 31→0 is seamless.
- Allocate: alloc_valid & alloc_ready at an edge writes the entry at tail (valid = 1, done = 0, failed = 0, payload) and increments tail.
- alloc_ready is computed from registered count only; there is no bypass from a same-cycle commit, so a full ROB refuses allocation even while retiring.
- Completion: any cmp_*_valid sets done[idx]; cmp_term_valid additionally sets failed[idx] = cmp_term_failed.
  - Multiple ports hitting the same index in one cycle are OR'd.
  - A completion to an entry with valid = 0 is ignored.
- Commit condition: valid[head] & done[head] from registered state.
- Commit action:
  - Registered outputs assert on the next edge: commit_valid = 1, payload from entry, free_valid = dmask.
  - Clears valid[head] and increments head.
  - Completion-to-commit latency is one cycle minimum; commit throughput is 1 per cycle.
- Simultaneous alloc + commit: count unchanged, both proceed (subject to the no-bypass ready rule).
- Failed term commit:
  - Commit outputs asserted as normal; flush pulses high in the same cycle.
  - Same edge: all entries invalidated, head = tail = 0, count = 0.
  - alloc_ready is 0 during the flush cycle; allocation in that cycle is dropped.
  - Completions landing in the flush cycle are discarded.
  - Younger entries' phys tags are not freed here; free-list recovery belongs to rename.
- Non-failed term commit behaves as an ordinary commit.
- Empty: no commit; all commit outputs deassert (payload holds last value, valids 0).

Optional Feature:
- ROB_PERF_EN defined:
  - Adds outputs perf_commits (32-bit) and perf_flushes (16-bit).
  - Both reset to 0, increment on commit_valid and flush respectively, and wrap on overflow.
- ROB_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then alloc 3 ops (entries 0,1,2); complete in order 2,0,1 → commits for 0,1,2 in consecutive cycles after entry 1 completes; free_phys matches each alloc_old_phys.
- Fill 32 entries with no completions → alloc_ready = 0 after the 32nd alloc, alloc_entry wrapped through 31; a commit plus same-cycle alloc_valid is refused; alloc_ready returns 1 the next cycle.
- Same-cycle cmp_arith_entry = 4 and cmp_mem_entry = 4, plus term on 5, with entries 0-3 already done → 6 commits in 6 consecutive cycles, no duplicates.
- Alloc 0 (arith), 1 (term), 2 (arith); complete all, term failed = 1 → commits 0 and 1, flush = 1 with commit of 1, entry 2 never commits, empty = 1 next cycle, alloc_entry = 0.
- Drop rst mid-stream with 10 entries live → outputs zero immediately (asynchronous), empty = 1, the next alloc gets entry 0.
- With ROB_PERF_EN: 100 commits, 3 flushes → perf_commits = 100, perf_flushes = 3.
